// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_t          : sequencer states (IDLE, RD_WAIT, WR, RESP)
//   PORT_CPU/HOST    : requester indices (0 = CPU control FSM, 1 = host readback)
//   READ_LAT_DEFAULT : default memory read latency in cycles
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  localparam int READ_LAT_DEFAULT = 3;

endpackage

// File: rtl/arb_rr_pick2.sv
// Combinational two-way request picker.
//   req0, req1 : pending requests from port 0 / port 1
//   last       : index of the most recently granted port
//   valid      : at least one request is pending
//   idx        : index of the port to grant
// Build option MEM_ARB_FIXED_PRIO_EN: when defined, port 1 wins every tie
// (host preempts CPU); otherwise a tie goes to the port that was not granted
// last (round-robin).
module arb_rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic idx
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  // The history bit is still tracked by the caller but plays no part here.
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    valid = req0 | req1;
    idx   = PORT_CPU;
    if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      idx = PORT_HOST;
`else
      idx = ~last;
`endif
    end else if (req1) begin
      idx = PORT_HOST;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one MemReadWrite instance between two requesters with a single
// outstanding access, a fixed-latency read sequencer and a one-cycle done
// pulse per access.
//   clk, rst               : clock, asynchronous active-high reset
//   req/we/addr/wdata{0,1} : level request and access descriptor per port
//   done{0,1}, rdata{0,1}  : completion pulse and read data per port
//   busy                   : sequencer is not IDLE
//   mem_en/ren/wen/addr/din, mem_dout : memory command and read data
// All outputs come straight from registers.
// Build option MEM_ARB_FIXED_PRIO_EN selects fixed host priority on ties
// (handled inside arb_rr_pick2).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = READ_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  // READ_LAT is legal up to 15, so four bits hold READ_LAT-1.
  localparam int LAT_W = 4;

  state_t                   state_reg, state_next;
  logic [LAT_W-1:0]         lat_cnt_reg, lat_cnt_next;
  logic                     owner_reg, owner_next;
  logic                     last_reg, last_next;
  logic                     mem_en_reg, mem_en_next;
  logic                     mem_ren_reg, mem_ren_next;
  logic                     mem_wen_reg, mem_wen_next;
  logic [ADDR_W-1:0]        mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]        mem_din_reg, mem_din_next;
  logic [1:0]               done_reg, done_next;
  logic [1:0][DATA_W-1:0]   rdata_reg, rdata_next;
  logic                     busy_reg, busy_next;

  logic                     grant_valid;
  logic                     grant_idx;
  logic                     sel_we;
  logic [ADDR_W-1:0]        sel_addr;
  logic [DATA_W-1:0]        sel_wdata;

  arb_rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_reg),
    .valid (grant_valid),
    .idx   (grant_idx)
  );

  assign sel_we    = grant_idx ? we1    : we0;
  assign sel_addr  = grant_idx ? addr1  : addr0;
  assign sel_wdata = grant_idx ? wdata1 : wdata0;

  always_comb begin
    state_next    = state_reg;
    lat_cnt_next  = lat_cnt_reg;
    owner_next    = owner_reg;
    last_next     = last_reg;
    mem_en_next   = mem_en_reg;
    mem_ren_next  = mem_ren_reg;
    mem_wen_next  = mem_wen_reg;
    mem_addr_next = mem_addr_reg;
    mem_din_next  = mem_din_reg;
    rdata_next    = rdata_reg;
    // done is a pulse: it is only ever set on the transition into RESP.
    done_next     = 2'b00;

    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          owner_next    = grant_idx;
          last_next     = grant_idx;
          mem_en_next   = 1'b1;
          mem_addr_next = sel_addr;
          if (sel_we) begin
            mem_wen_next = 1'b1;
            mem_din_next = sel_wdata;
            state_next   = WR;
          end else begin
            mem_ren_next = 1'b1;
            lat_cnt_next = LAT_W'(READ_LAT - 1);
            state_next   = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        // Command is held for READ_LAT cycles; mem_dout is sampled on the
        // last of them.
        if (lat_cnt_reg == '0) begin
          mem_en_next           = 1'b0;
          mem_ren_next          = 1'b0;
          rdata_next[owner_reg] = mem_dout;
          done_next[owner_reg]  = 1'b1;
          state_next            = RESP;
        end else begin
          lat_cnt_next = lat_cnt_reg - 1'b1;
        end
      end

      WR: begin
        mem_en_next          = 1'b0;
        mem_wen_next         = 1'b0;
        done_next[owner_reg] = 1'b1;
        state_next           = RESP;
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      lat_cnt_reg  <= '0;
      owner_reg    <= PORT_CPU;
      last_reg     <= PORT_HOST;   // port 0 wins the first tie
      mem_en_reg   <= 1'b0;
      mem_ren_reg  <= 1'b0;
      mem_wen_reg  <= 1'b0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
      done_reg     <= '0;
      rdata_reg    <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lat_cnt_reg  <= lat_cnt_next;
      owner_reg    <= owner_next;
      last_reg     <= last_next;
      mem_en_reg   <= mem_en_next;
      mem_ren_reg  <= mem_ren_next;
      mem_wen_reg  <= mem_wen_next;
      mem_addr_reg <= mem_addr_next;
      mem_din_reg  <= mem_din_next;
      done_reg     <= done_next;
      rdata_reg    <= rdata_next;
      busy_reg     <= busy_next;
    end
  end

  assign done0    = done_reg[0];
  assign done1    = done_reg[1];
  assign rdata0   = rdata_reg[0];
  assign rdata1   = rdata_reg[1];
  assign busy     = busy_reg;
  assign mem_en   = mem_en_reg;
  assign mem_ren  = mem_ren_reg;
  assign mem_wen  = mem_wen_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_din  = mem_din_reg;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single MemReadWrite instance between two requesters: port 0 = CPU control FSM (fetch/load/store), port 1 = host/inference readback port.
- Replaces ad-hoc RED wait states with a fixed-latency read sequencer and one response pulse per access.
- Single outstanding access; round-robin on simultaneous requests.

Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 32, memory data width
- READ_LAT, 3, cycles mem_en/mem_ren/mem_addr must be held before mem_dout is valid (legal 1..15)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req0  in  1  port 0 request, level, held until done0
- we0  in  1  port 0: 1 = write, 0 = read
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- done0  out  1  port 0 one-cycle completion pulse
- rdata0  out  DATA_W  port 0 read data, valid when done0 and we0 was 0
- req1, we1, addr1, wdata1, done1, rdata1  same as port 0, for port 1
- busy  out  1  high whenever state != IDLE
- mem_en  out  1  to MemReadWrite en
- mem_ren  out  1  to MemReadWrite ren
- mem_wen  out  1  to MemReadWrite wen
- mem_addr  out  ADDR_W  to MemReadWrite addr
- mem_din  out  DATA_W  to MemReadWrite din
- mem_dout  in  DATA_W  from MemReadWrite dout

Behaviour:
- Clock/reset: one clock (clk); rst is asynchronous, active-high. All outputs are registered.
- Reset values: every output 0. State = IDLE, lat_cnt = 0, owner = 0, last = 1 (port 0 wins the first tie). Reset mid-access aborts it with no done pulse.
- States: IDLE, RD_WAIT, WR, RESP.
- IDLE: req sampled only here.
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both: grant the port != last.
  - On grant: owner = port, last = port, latch addr into mem_addr, mem_en = 1.
    - Read: mem_ren = 1, lat_cnt = READ_LAT-1, go to RD_WAIT.
    - Write: mem_wen = 1, mem_din = wdata, go to WR.
- RD_WAIT: mem_en, mem_ren and mem_addr are held stable.
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0: capture mem_dout into rdata[owner], drop mem_en/mem_ren, go to RESP.
- WR: lasts one cycle (mem_wen high exactly one cycle). Then drop mem_en/mem_wen and go to RESP.
- RESP: done[owner] = 1 for exactly this cycle. req ignored. Next state IDLE.
- Latency, req first seen high in cycle 0:
  - Read: mem command in cycles 1..READ_LAT; done + rdata in cycle READ_LAT+1.
  - Write: command in cycle 1; done in cycle 2.
  - IDLE cycle follows each RESP. Throughput: read READ_LAT+2 cycles/access, write 3 cycles/access.
- Requester rules:
  - addr/we/wdata stay stable while req is high until done.
  - Deassert req in the cycle after done, or keep it high with new addr/we/wdata for a back-to-back access.
- rdataN holds its last value until overwritten by a later read on the same port. Writes do not modify rdataN.
- Fairness: while both ports hold req continuously, grants strictly alternate. Neither port waits more than one foreign access.
- req changing while not in IDLE: no effect. Sampled at the next IDLE.
- Addresses are used as-is (no wrap or bounds check). mem_addr is zero-extended if ADDR_W is smaller than the memory's width.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
  - Defined: port 1 wins every simultaneous request (host preempts CPU fetch). `last` is still updated but ignored.
  - Undefined: round-robin as above.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE, RD_WAIT, WR, RESP)
  - port index constants PORT_CPU = 0, PORT_HOST = 1
  - default READ_LAT
- One sub-module, arb_rr_pick2: combinational 2-way pick(req0, req1, last) -> grant valid + index. It holds the MEM_ARB_FIXED_PRIO_EN switch.
- The latency counter stays in the top module.

Test Plan:
- Single read: READ_LAT=3, port 0 reads addr 0x0004 with mem holding 0xDEADBEEF at 0x0004.
  → mem_en/mem_ren high cycles 1-3 with mem_addr=0x0004; done0 in cycle 4 with rdata0=0xDEADBEEF; busy low in cycle 5.
- Single write: port 1 writes 0x12345678 to 0x0010.
  → mem_wen high only in cycle 1; done1 in cycle 2; a following port 0 read of 0x0010 returns 0x12345678.
- Contention: req0 and req1 both high from reset, 4 reads each.
  → grant order 0,1,0,1,...; no port gets two consecutive grants. With MEM_ARB_FIXED_PRIO_EN: all port 1 accesses complete first.
- Back-to-back: port 0 keeps req0 high and changes addr after each done0.
  → consecutive reads spaced exactly READ_LAT+2 cycles; no duplicate access to the old address.
- Reset mid-read: assert rst in cycle 2 of a read.
  → all outputs 0 asynchronously; no done0 afterwards. After release, a new req1 is granted immediately (last=1 reset does not block port 1 when alone).
- Latency sweep: READ_LAT=1 and READ_LAT=15.
  → done in cycle READ_LAT+1 for both, with mem_ren high exactly READ_LAT cycles.
